// File: rtl/fir_inverse_15.sv
// Inverse FIR (deconvolution): e[n] = d[n] - sum_{k=1..N-1} c[k]*e[n-k], 32-bit wraparound.
// One shared MAC stepped by a 3-state FSM; accepts one sample every N+1 cycles.
module fir_inverse_15 #(
   parameter int NUM_COEFFS = 15
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic signed [31:0]               data_in,
   input  logic                             data_in_valid,
   output logic                             data_in_ready,
   input  logic signed [NUM_COEFFS-1:0][7:0] coeffs,
   output logic signed [31:0]               data_out,
   output logic                             data_out_valid
);

   localparam int KW = $clog2(NUM_COEFFS);
   localparam logic [KW-1:0] K_LAST = KW'(NUM_COEFFS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   logic [1:0]          state;
   logic [KW-1:0]       k;
   logic signed [31:0]  acc;
   logic signed [31:0]  d_reg;
   logic signed [7:0]   c_sh [1:NUM_COEFFS-1];
   logic signed [31:0]  h    [0:NUM_COEFFS-2];

   logic signed [31:0]  c_ext;
   logic signed [31:0]  h_sel;
   logic signed [31:0]  prod;
   logic signed [31:0]  e_new;

   // Product is truncated to the low 32 bits, matching the forward filter's wrap.
   always_comb begin
      c_ext = '0;
      h_sel = '0;
      if (state == MAC) begin
         c_ext = {{24{c_sh[k][7]}}, c_sh[k]};
         h_sel = h[k - 1'b1];
      end
      prod  = c_ext * h_sel;
      e_new = d_reg - acc;
   end

   assign data_in_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         k              <= '0;
         acc            <= '0;
         d_reg          <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         for (int i = 0; i < NUM_COEFFS - 1; i++) h[i] <= '0;
         for (int i = 1; i < NUM_COEFFS; i++) c_sh[i] <= '0;
      end else begin
         data_out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (data_in_valid) begin
                  d_reg <= data_in;
                  for (int i = 1; i < NUM_COEFFS; i++) c_sh[i] <= $signed(coeffs[i]);
                  acc   <= '0;
                  k     <= KW'(1);
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc + prod;
               if (k == K_LAST) state <= OUT;
               else             k     <= k + 1'b1;
            end
            OUT: begin
               data_out       <= e_new;
               data_out_valid <= 1'b1;
               h[0]           <= e_new;
               for (int i = 1; i < NUM_COEFFS - 1; i++) h[i] <= h[i-1];
               k              <= '0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
